// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 decode definitions for the decode/operand-fetch stage:
//   - base opcode constants (OP_*)
//   - imm_fmt_t   : immediate encoding class of an instruction
//   - stage_state_t : occupancy of the ID/EX pipeline register
//   - helpers mapping an opcode to its immediate format and source usage
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_t;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } stage_state_t;

   function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
         OP_STORE:                 return IMM_S;
         OP_BRANCH:                return IMM_B;
         OP_LUI, OP_AUIPC:         return IMM_U;
         OP_JAL:                   return IMM_J;
         default:                  return IMM_NONE;
      endcase
   endfunction

   // rs1 field is part of the immediate/unused for U-type and JAL.
   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
   endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator: instruction word -> XLEN-bit immediate,
// sign-extended from instr[31]. Opcodes without an immediate yield 0.
// Ports:
//   instr [31:0]     in   instruction word
//   imm   [XLEN-1:0] out  decoded immediate
// ---------------------------------------------------------------------------
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic funct3_unused;
   assign funct3_unused = ^instr[14:12];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      imm = '0;
      case (imm_fmt_of(instr[6:0]))
         IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
         IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode/operand-fetch stage in front of execute. Drives register-file read
// addresses straight from the fetched instruction, selects operands (x0 ->
// 0, writeback bypass, else RF data), interlocks on a load-use hazard and
// registers a decoded bundle for execute behind a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   if_valid/if_ready        fetch handshake; if_instr, if_pc payload
//   rf_raddr1/2, rf_rdata1/2 register-file read side
//   wb_we, wb_rd, wb_data    writeback port (bypass source)
//   flush                    redirect: kills held bundle and incoming instr
//   ex_valid/ex_ready        execute handshake; ex_* registered bundle
//   stall_cnt                (ID_EX_STALL_CNT_EN only) saturating count of
//                            cycles where fetch was valid but not accepted
//
// Build option: define ID_EX_STALL_CNT_EN to add the stall_cnt port.
// ---------------------------------------------------------------------------
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rf_raddr1,
   output logic [4:0]      rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_op1,
   output logic [XLEN-1:0] ex_op2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_is_load,
   output logic            ex_regwrite
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            is_load;
      logic            regwrite;
   } bundle_t;

   logic [6:0]      opcode;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            hazard;
   logic            fire;
   logic            load;

   stage_state_t    state_q, state_d;
   bundle_t         bundle_q, bundle_d;

   assign opcode    = if_instr[6:0];
   assign rd        = if_instr[11:7];
   assign rs1       = if_instr[19:15];
   assign rs2       = if_instr[24:20];
   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (if_instr),
      .imm   (imm)
   );

   // Bypass covers the RF write landing this same cycle; rs!=0 already
   // excludes a writeback to x0.
   always_comb begin
      op1 = rf_rdata1;
      if (rs1 == 5'd0)                    op1 = '0;
      else if (wb_we && (wb_rd == rs1))   op1 = wb_data;
   end

   always_comb begin
      op2 = rf_rdata2;
      if (rs2 == 5'd0)                    op2 = '0;
      else if (wb_we && (wb_rd == rs2))   op2 = wb_data;
   end

   // A load still sitting in ID/EX has no data yet; hold the consumer back one
   // cycle. Only fields the opcode really reads may raise the interlock.
   assign hazard = (state_q == ST_FULL) && bundle_q.is_load && (bundle_q.rd != 5'd0) &&
                   ((uses_rs1(opcode) && (rs1 == bundle_q.rd)) ||
                    (uses_rs2(opcode) && (rs2 == bundle_q.rd)));

   assign if_ready = rst && !hazard && ((state_q == ST_EMPTY) || ex_ready);
   assign fire     = if_valid && if_ready;
   // A fire during flush is accepted from fetch but dropped here.
   assign load     = fire && !flush;

   always_comb begin
      state_d  = state_q;
      bundle_d = bundle_q;
      case (state_q)
         ST_EMPTY: if (load) state_d = ST_FULL;
         ST_FULL: begin
            if (flush)                state_d = ST_EMPTY;
            else if (!fire && ex_ready) state_d = ST_EMPTY;
         end
         default:  state_d = ST_EMPTY;
      endcase
      if (load) begin
         bundle_d.pc       = if_pc;
         bundle_d.op1      = op1;
         bundle_d.op2      = op2;
         bundle_d.imm      = imm;
         bundle_d.rd       = rd;
         bundle_d.opcode   = opcode;
         bundle_d.funct3   = if_instr[14:12];
         bundle_d.funct7b5 = if_instr[30];
         bundle_d.is_load  = (opcode == OP_LOAD);
         bundle_d.regwrite = (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         state_q  <= ST_EMPTY;
         bundle_q <= '{pc: RESET_PC, default: '0};
      end else begin
         state_q  <= state_d;
         bundle_q <= bundle_d;
      end
   end

   assign ex_valid    = (state_q == ST_FULL);
   assign ex_pc       = bundle_q.pc;
   assign ex_op1      = bundle_q.op1;
   assign ex_op2      = bundle_q.op2;
   assign ex_imm      = bundle_q.imm;
   assign ex_rd       = bundle_q.rd;
   assign ex_opcode   = bundle_q.opcode;
   assign ex_funct3   = bundle_q.funct3;
   assign ex_funct7b5 = bundle_q.funct7b5;
   assign ex_is_load  = bundle_q.is_load;
   assign ex_regwrite = bundle_q.regwrite;

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (if_valid && !if_ready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model plus an
// in-order scoreboard of issued PCs.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam logic [31:0] RESET_PC_TB = 32'h0000_1000;

   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_AUIPC  = 7'b0010111;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_IMM    = 7'b0010011;
   localparam logic [6:0] T_REG    = 7'b0110011;
   localparam logic [6:0] T_FENCE  = 7'b0001111;

   logic        clk = 1'b0;
   logic        rst, if_valid, wb_we, flush, ex_ready;
   logic [31:0] if_instr, if_pc, rf_rdata1, rf_rdata2, wb_data;
   logic [4:0]  wb_rd;
   logic        if_ready, ex_valid, ex_funct7b5, ex_is_load, ex_regwrite;
   logic [4:0]  rf_raddr1, rf_raddr2, ex_rd;
   logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RESET_PC(RESET_PC_TB)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
      .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite)
`ifdef ID_EX_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc, op1, op2, imm;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic        f7b5, is_load, regwrite;
   } bundle_t;

   bundle_t     m_b;
   logic        m_valid = 1'b0;
   logic        m_rst_state = 1'b0;
   logic [31:0] m_stall = '0;
   logic [31:0] sb [$];
   logic        seen_ready;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [6:0]  op_pool [10] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH,
                                  T_LOAD, T_STORE, T_IMM, T_REG, T_FENCE};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      int v;
      case (i[6:0])
         T_IMM, T_LOAD, T_JALR: v = $signed(i[31:20]);
         T_STORE:               v = $signed({i[31:25], i[11:7]});
         T_BRANCH:              v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
         T_LUI, T_AUIPC:        v = {i[31:12], 12'h000};
         T_JAL:                 v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
         default:               v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rdata,
                                               input logic we, input logic [4:0] wrd,
                                               input logic [31:0] wd);
      if (rs == 0) return 0;
      if (we && wrd == rs) return wd;
      return rdata;
   endfunction

   function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      bundle_t b;
      b.pc       = pc;
      b.op1      = ref_operand(i[19:15], rf_rdata1, wb_we, wb_rd, wb_data);
      b.op2      = ref_operand(i[24:20], rf_rdata2, wb_we, wb_rd, wb_data);
      b.imm      = ref_imm(i);
      b.rd       = i[11:7];
      b.opcode   = i[6:0];
      b.f3       = i[14:12];
      b.f7b5     = i[30];
      b.is_load  = (i[6:0] == T_LOAD);
      b.regwrite = (i[11:7] != 0) && (i[6:0] != T_STORE) && (i[6:0] != T_BRANCH);
      return b;
   endfunction

   function automatic logic reads_rs1(input logic [6:0] op);
      return !(op == T_LUI || op == T_AUIPC || op == T_JAL);
   endfunction

   function automatic logic reads_rs2(input logic [6:0] op);
      return (op == T_REG || op == T_STORE || op == T_BRANCH);
   endfunction

   // One clock: check combinational outputs mid-cycle, advance the model,
   // then check registered outputs just after the edge.
   task automatic tick();
      logic    hz, exp_ready, fire;
      bundle_t nb;
      @(negedge clk);
      hz = m_valid && m_b.is_load && (m_b.rd != 0) &&
           ((reads_rs1(if_instr[6:0]) && if_instr[19:15] == m_b.rd) ||
            (reads_rs2(if_instr[6:0]) && if_instr[24:20] == m_b.rd));
      exp_ready  = rst && !hz && (!m_valid || ex_ready);
      seen_ready = if_ready;
      check("if_ready", {31'b0, if_ready}, {31'b0, exp_ready});
      check("rf_raddr1", {27'b0, rf_raddr1}, {27'b0, if_instr[19:15]});
      check("rf_raddr2", {27'b0, rf_raddr2}, {27'b0, if_instr[24:20]});
      fire = if_valid && exp_ready;
      if (rst && !flush && m_valid && ex_ready && sb.size() > 0)
         check("order", ex_pc, sb.pop_front());
      if (!rst || flush) sb.delete();
      else if (fire)     sb.push_back(if_pc);
      if (!rst) m_stall = '0;
      else if (if_valid && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      nb = ref_decode(if_instr, if_pc);
      @(posedge clk);
      #1;
      if (!rst) begin
         m_valid     = 1'b0;
         m_rst_state = 1'b1;
         m_b         = '{pc: RESET_PC_TB, default: '0};
      end else if (flush) begin
         m_valid = 1'b0;
      end else if (fire) begin
         m_valid     = 1'b1;
         m_rst_state = 1'b0;
         m_b         = nb;
      end else if (m_valid && ex_ready) begin
         m_valid = 1'b0;
      end
      check("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
      if (m_valid || m_rst_state) begin
         check("ex_pc", ex_pc, m_b.pc);
         check("ex_op1", ex_op1, m_b.op1);
         check("ex_op2", ex_op2, m_b.op2);
         check("ex_imm", ex_imm, m_b.imm);
         check("ex_ctrl", {13'b0, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_regwrite},
                          {13'b0, m_b.rd, m_b.opcode, m_b.f3, m_b.f7b5, m_b.is_load, m_b.regwrite});
      end
`ifdef ID_EX_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
   endtask

   task automatic present(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      if_valid = v;
      if_instr = instr;
      if_pc    = pc;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r        = $urandom;
      r[6:0]   = op_pool[$urandom_range(0, 9)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] pc_ctr;
      rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      rf_rdata1 = '0; rf_rdata2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      flush = 1'b0; ex_ready = 1'b1;

      // Reset state
      tick(); tick();
      check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      check("rst_ex_pc", ex_pc, RESET_PC_TB);
      check("rst_ex_imm", ex_imm, 32'd0);
      check("rst_if_ready", {31'b0, seen_ready}, 32'd0);
      rst = 1'b1;

      // addi x5,x1,-3
      present(1'b1, 32'hFFD08293, 32'h100); rf_rdata1 = 32'd1;
      tick();
      check("addi_valid", {31'b0, ex_valid}, 32'd1);
      check("addi_op1", ex_op1, 32'd1);
      check("addi_imm", ex_imm, 32'hFFFF_FFFD);
      check("addi_rd", {27'b0, ex_rd}, 32'd5);
      check("addi_regwrite", {31'b0, ex_regwrite}, 32'd1);

      // add x3,x2,x2 with writeback bypass, then with wb_rd=0
      present(1'b1, 32'h002101B3, 32'h104); rf_rdata1 = 32'd2; rf_rdata2 = 32'd2;
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hA5;
      tick();
      check("byp_op1", ex_op1, 32'hA5);
      check("byp_op2", ex_op2, 32'hA5);
      present(1'b1, 32'h002101B3, 32'h108); wb_rd = 5'd0;
      tick();
      check("nobyp_op1", ex_op1, 32'd2);
      check("nobyp_op2", ex_op2, 32'd2);
      wb_we = 1'b0;

      // Immediate formats
      present(1'b1, 32'hFE112E23, 32'h10C); tick();
      check("imm_s", ex_imm, 32'hFFFF_FFFC);
      check("sw_regwrite", {31'b0, ex_regwrite}, 32'd0);
      present(1'b1, 32'hFE000CE3, 32'h110); tick();
      check("imm_b", ex_imm, 32'hFFFF_FFF8);
      present(1'b1, 32'h123452B7, 32'h114); tick();
      check("imm_u", ex_imm, 32'h1234_5000);
      present(1'b1, 32'h001000EF, 32'h118); tick();
      check("imm_j", ex_imm, 32'h0000_0800);
      present(1'b0, '0, '0); tick();

      // Load-use: exactly one bubble
      rst = 1'b0; tick(); rst = 1'b1;
      present(1'b1, 32'h0000A303, 32'h200); tick();          // lw x6,0(x1)
      check("lw_loaded", {31'b0, ex_is_load}, 32'd1);
      present(1'b1, 32'h006303B3, 32'h204); tick();          // add x7,x6,x6
      check("lu_stall_ready", {31'b0, seen_ready}, 32'd0);
      check("lu_bubble", {31'b0, ex_valid}, 32'd0);
      tick();
      check("lu_issue_ready", {31'b0, seen_ready}, 32'd1);
      check("lu_add_rd", {27'b0, ex_rd}, 32'd7);
`ifdef ID_EX_STALL_CNT_EN
      check("lu_stall_cnt", stall_cnt, 32'd1);
`endif
      present(1'b0, '0, '0); tick();

      // Backpressure: held bundle stable for 3 cycles, then next one issues
      ex_ready = 1'b0;
      present(1'b1, 32'h00108093, 32'h300); tick();
      present(1'b1, 32'h00210113, 32'h304);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_ready", {31'b0, seen_ready}, 32'd0);
         check("bp_hold_pc", ex_pc, 32'h300);
      end
      ex_ready = 1'b1; tick();
      check("bp_release_pc", ex_pc, 32'h304);
      present(1'b0, '0, '0); tick();

      // Flush in the same cycle as fire, then flush of a held bundle
      present(1'b1, 32'h00318193, 32'h400); flush = 1'b1; tick();
      check("flush_fire", {31'b0, ex_valid}, 32'd0);
      flush = 1'b0; present(1'b0, '0, '0); tick();
      check("flush_gone", {31'b0, ex_valid}, 32'd0);
      ex_ready = 1'b0; present(1'b1, 32'h00420213, 32'h404); tick();
      present(1'b0, '0, '0); flush = 1'b1; tick();
      check("flush_held", {31'b0, ex_valid}, 32'd0);
      flush = 1'b0;

      // Reset while stalled drops the held bundle
      present(1'b1, 32'h00528293, 32'h500); tick();
      present(1'b1, 32'h00630313, 32'h504); rst = 1'b0; tick();
      check("rst_stall_valid", {31'b0, ex_valid}, 32'd0);
      check("rst_stall_pc", ex_pc, RESET_PC_TB);
      rst = 1'b1; ex_ready = 1'b1; present(1'b0, '0, '0); tick();

      // Random traffic
      pc_ctr = 32'h8000;
      for (int n = 0; n < 3000; n++) begin
         present($urandom_range(0, 3) != 0, rand_instr(), pc_ctr);
         pc_ctr    += 4;
         rf_rdata1 = $urandom;
         rf_rdata2 = $urandom;
         wb_we     = $urandom_range(0, 1) != 0;
         wb_rd     = 5'($urandom_range(0, 3));
         wb_data   = $urandom;
         ex_ready  = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 19) == 0;
         rst       = $urandom_range(0, 149) != 0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
